// File: rtl/uart_paddle_ctrl.sv
// rtl/uart_paddle_ctrl.sv - UART key decoder driving Pong paddle positions and game control
// Optional feature macro: UART_PADDLE_CASE_FOLD_EN (uppercase R P N W S I K act like lowercase).
module uart_paddle_ctrl #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115200,
  parameter int STEP     = 16,
  parameter int Y_MAX    = 416,
  parameter int Y_INIT   = 208
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic [31:0] y_pos_1,
  output logic [31:0] y_pos_2,
  output logic [31:0] ctrl,
  output logic        key_valid,
  output logic        rx_err
);

  localparam int          CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int          HALF_BIT     = CLKS_PER_BIT / 2;
  localparam logic [15:0] BIT_LAST     = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST    = 16'(HALF_BIT - 1);
  localparam logic [8:0]  STEP_V       = 9'(STEP);
  localparam logic [8:0]  Y_MAX_V      = 9'(Y_MAX);
  localparam logic [8:0]  Y_INIT_V     = 9'(Y_INIT);
  localparam logic [8:0]  DOWN_LIMIT   = 9'(Y_MAX - STEP);

  localparam logic [1:0]  CTRL_STOP    = 2'b00;
  localparam logic [1:0]  CTRL_RUN     = 2'b01;
  localparam logic [1:0]  CTRL_RESTART = 2'b10;

  localparam logic [7:0]  KEY_RUN      = 8'h72;  // 'r'
  localparam logic [7:0]  KEY_STOP     = 8'h70;  // 'p'
  localparam logic [7:0]  KEY_RESTART  = 8'h6E;  // 'n'
  localparam logic [7:0]  KEY_P1_UP    = 8'h77;  // 'w'
  localparam logic [7:0]  KEY_P1_DOWN  = 8'h73;  // 's'
  localparam logic [7:0]  KEY_P2_UP    = 8'h69;  // 'i'
  localparam logic [7:0]  KEY_P2_DOWN  = 8'h6B;  // 'k'

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  logic        rx_meta_q;
  logic        rx_s_q;
  state_t      state_q;
  logic [15:0] cnt_q;
  logic [2:0]  bit_q;
  logic [7:0]  shift_q;
  logic        key_valid_q;
  logic        rx_err_q;
  logic [8:0]  y1_q, y1_d;
  logic [8:0]  y2_q, y2_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic        accept;
  logic [7:0]  key;

  function automatic logic [8:0] step_up(input logic [8:0] y);
    return (y < STEP_V) ? 9'd0 : y - STEP_V;
  endfunction

  function automatic logic [8:0] step_down(input logic [8:0] y);
    return (y > DOWN_LIMIT) ? Y_MAX_V : y + STEP_V;
  endfunction

  // Two-flop synchronizer; flops reset to the idle-high line level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // 8N1 receive FSM with registered key_valid / rx_err pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      key_valid_q <= 1'b0;
      rx_err_q    <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      rx_err_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (!rx_s_q) state_q <= S_START;
        end
        S_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            // A start bit that is high again at its centre was only a glitch
            state_q <= rx_s_q ? S_IDLE : S_DATA;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            shift_q <= {rx_s_q, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) state_q <= S_STOP;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q <= '0;
            if (rx_s_q) begin
              key_valid_q <= 1'b1;
              state_q     <= S_IDLE;
            end else begin
              rx_err_q <= 1'b1;
              state_q  <= S_BREAK;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_BREAK: begin
          // Wait out a held-low line so it is not mistaken for a new start bit
          if (rx_s_q) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Byte acceptance is the stop-bit sample itself, so outputs move with key_valid
  assign accept = (state_q == S_STOP) && (cnt_q == BIT_LAST) && rx_s_q;

  // Key decoder: next paddle positions and control word
  always_comb begin
    key    = shift_q;
    y1_d   = y1_q;
    y2_d   = y2_q;
    ctrl_d = ctrl_q;
`ifdef UART_PADDLE_CASE_FOLD_EN
    if (shift_q >= 8'h41 && shift_q <= 8'h5A) key = shift_q | 8'h20;
`else
`endif
    if (accept) begin
      case (key)
        KEY_RUN:  ctrl_d = CTRL_RUN;
        KEY_STOP: ctrl_d = CTRL_STOP;
        KEY_RESTART: begin
          ctrl_d = CTRL_RESTART;
          y1_d   = Y_INIT_V;
          y2_d   = Y_INIT_V;
        end
        KEY_P1_UP:   if (ctrl_q == CTRL_RUN) y1_d = step_up(y1_q);
        KEY_P1_DOWN: if (ctrl_q == CTRL_RUN) y1_d = step_down(y1_q);
        KEY_P2_UP:   if (ctrl_q == CTRL_RUN) y2_d = step_up(y2_q);
        KEY_P2_DOWN: if (ctrl_q == CTRL_RUN) y2_d = step_down(y2_q);
        default: ;
      endcase
    end
  end

  // Game state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y1_q   <= Y_INIT_V;
      y2_q   <= Y_INIT_V;
      ctrl_q <= CTRL_STOP;
    end else begin
      y1_q   <= y1_d;
      y2_q   <= y2_d;
      ctrl_q <= ctrl_d;
    end
  end

  assign y_pos_1   = {23'd0, y1_q};
  assign y_pos_2   = {23'd0, y2_q};
  assign ctrl      = {30'd0, ctrl_q};
  assign key_valid = key_valid_q;
  assign rx_err    = rx_err_q;

endmodule

// File: tb/tb_uart_paddle_ctrl.sv
// tb/tb_uart_paddle_ctrl.sv - self-checking bench for uart_paddle_ctrl
module tb_uart_paddle_ctrl;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
  localparam int LAT  = 2 + HALF + 9 * CPB + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx = 1'b1;
  logic [31:0] y_pos_1, y_pos_2, ctrl;
  logic        key_valid, rx_err;

  typedef struct {
    logic        err;
    logic [31:0] y1;
    logic [31:0] y2;
    logic [31:0] c;
    int          cyc;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_cyc = 0;
  int m_y1 = 208;
  int m_y2 = 208;
  int m_c = 0;

  uart_paddle_ctrl #(
    .CLK_FREQ(1_600_000),
    .BAUD    (100_000),
    .STEP    (16),
    .Y_MAX   (416),
    .Y_INIT  (208)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .y_pos_1  (y_pos_1),
    .y_pos_2  (y_pos_2),
    .ctrl     (ctrl),
    .key_valid(key_valid),
    .rx_err   (rx_err)
  );

  always #5 clk = ~clk;

  // Output monitor: every pulse cycle is captured with the outputs at that time
  always begin
    @(posedge clk);
    cyc++;
    #1;
    if (key_valid || rx_err) obs_q.push_back('{rx_err, y_pos_1, y_pos_2, ctrl, cyc});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic void apply(input logic [7:0] b0);
    logic [7:0] b;
    b = b0;
`ifdef UART_PADDLE_CASE_FOLD_EN
    if (b >= 8'h41 && b <= 8'h5A) b = b | 8'h20;
`endif
    case (b)
      8'h72: m_c = 1;
      8'h70: m_c = 0;
      8'h6E: begin m_c = 2; m_y1 = 208; m_y2 = 208; end
      8'h77: if (m_c == 1) m_y1 = (m_y1 < 16) ? 0 : m_y1 - 16;
      8'h73: if (m_c == 1) m_y1 = (m_y1 > 400) ? 416 : m_y1 + 16;
      8'h69: if (m_c == 1) m_y2 = (m_y2 < 16) ? 0 : m_y2 - 16;
      8'h6B: if (m_c == 1) m_y2 = (m_y2 > 400) ? 416 : m_y2 + 16;
      default: ;
    endcase
  endfunction

  task automatic send_frame(input logic [7:0] b, input logic stop);
    @(posedge clk); #1;
    rx = 1'b0;
    start_cyc = cyc;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(posedge clk); #1;
      rx = b[i];
    end
    repeat (CPB) @(posedge clk); #1;
    rx = stop;
    repeat (CPB) @(posedge clk); #1;
    rx = 1'b1;
  endtask

  task automatic check_event(input string tag);
    ev_t o, x;
    int n;
    n = 0;
    while (obs_q.size() == 0 && n < 4 * CPB) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    assert (obs_q.size() != 0) else begin
      failures++;
      $error("FAIL %s.timeout observed=no_pulse expected=pulse", tag);
    end
    if (obs_q.size() != 0 && exp_q.size() != 0) begin
      o = obs_q.pop_front();
      x = exp_q.pop_front();
      chk({tag, ".err"}, {31'd0, o.err}, {31'd0, x.err});
      chk({tag, ".y1"}, o.y1, x.y1);
      chk({tag, ".y2"}, o.y2, x.y2);
      chk({tag, ".ctrl"}, o.c, x.c);
      checks++;
      assert ((o.cyc - start_cyc) >= x.cyc - 1 && (o.cyc - start_cyc) <= x.cyc + 1) else begin
        failures++;
        $error("FAIL %s.latency observed=%0d expected=%0d", tag, o.cyc - start_cyc, x.cyc);
      end
    end
    chk({tag, ".single"}, obs_q.size(), 0);
  endtask

  task automatic send_key(input logic [7:0] b, input logic stop, input string tag);
    if (stop) begin
      apply(b);
      exp_q.push_back('{1'b0, m_y1, m_y2, m_c, LAT});
    end else begin
      exp_q.push_back('{1'b1, m_y1, m_y2, m_c, LAT});
    end
    send_frame(b, stop);
    check_event(tag);
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".y1"}, y_pos_1, m_y1);
    chk({tag, ".y2"}, y_pos_2, m_y2);
    chk({tag, ".ctrl"}, ctrl, m_c);
    chk({tag, ".kv"}, {31'd0, key_valid}, 0);
    chk({tag, ".err"}, {31'd0, rx_err}, 0);
  endtask

  initial begin
    logic [7:0] kb;

    repeat (5) @(posedge clk); #1;
    check_outputs("reset");
    reset = 1'b1;
    repeat (5) @(posedge clk); #1;

    send_key(8'h77, 1'b1, "w_in_stop");
    send_key(8'h72, 1'b1, "r");
    send_key(8'h77, 1'b1, "w_run");
    send_key(8'h6B, 1'b1, "k_run");
    send_key(8'h57, 1'b1, "upper_W");
    send_key(8'h41, 1'b1, "other_A");

    for (int i = 0; i < 14; i++) send_key(8'h77, 1'b1, $sformatf("w_sat%0d", i));
    chk("y1_floor", y_pos_1, 0);
    for (int i = 0; i < 14; i++) send_key(8'h6B, 1'b1, $sformatf("k_sat%0d", i));
    chk("y2_ceiling", y_pos_2, 416);
    send_key(8'h73, 1'b1, "s_down");
    send_key(8'h69, 1'b1, "i_up");
    send_key(8'h6E, 1'b1, "n_restart");
    send_key(8'h77, 1'b1, "w_restart");

    // Stop bit low, then hold the line low through a long break
    send_key(8'h72, 1'b0, "bad_stop");
    rx = 1'b0;
    repeat (20 * CPB) @(posedge clk); #1;
    rx = 1'b1;
    repeat (3 * CPB) @(posedge clk); #1;
    chk("break_quiet", obs_q.size(), 0);
    check_outputs("break_hold");
    send_key(8'h72, 1'b1, "r_after_break");

    // Glitch shorter than half a bit on an idle line
    rx = 1'b0;
    repeat (HALF - 3) @(posedge clk); #1;
    rx = 1'b1;
    repeat (3 * CPB) @(posedge clk); #1;
    chk("glitch_quiet", obs_q.size(), 0);
    check_outputs("glitch");

    send_key(8'h73, 1'b1, "s_run");

    // Reset asserted during bit 4 of a 'w' frame
    kb = 8'h77;
    @(posedge clk); #1;
    rx = 1'b0;
    for (int i = 0; i < 5; i++) begin
      repeat (CPB) @(posedge clk); #1;
      rx = kb[i];
    end
    repeat (HALF) @(posedge clk); #1;
    reset = 1'b0;
    #1;
    m_y1 = 208; m_y2 = 208; m_c = 0;
    check_outputs("mid_reset");
    rx = 1'b1;
    repeat (5) @(posedge clk); #1;
    reset = 1'b1;
    repeat (3 * CPB) @(posedge clk); #1;
    chk("mid_reset_quiet", obs_q.size(), 0);
    send_key(8'h72, 1'b1, "r_after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
